// File: rtl/exec_mem_port_arbiter_if.sv
// rtl/exec_mem_port_arbiter_if.sv - request/response channels around the shared memory-port arbiter
//
// Groups the fetch channel, the execute load/store channel, the memory request/response
// channel and the status flags.
//   slave  : arbiter view (consumes fetch/data requests and memory responses)
//   master : environment view (requesters plus memory)
interface exec_mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = 8
);
  logic                  fetch_req_in;
  logic [ADDR_WIDTH-1:0] fetch_addr_in;
  logic                  fetch_ready_out;
  logic                  fetch_rsp_valid_out;
  logic [DATA_WIDTH-1:0] fetch_rsp_data_out;

  logic                  data_read_in;
  logic                  data_write_in;
  logic [ADDR_WIDTH-1:0] data_addr_in;
  logic [DATA_WIDTH-1:0] data_wdata_in;
  logic [MASK_WIDTH-1:0] data_mask_in;
  logic                  data_ready_out;
  logic                  data_rsp_valid_out;
  logic [DATA_WIDTH-1:0] data_rsp_data_out;

  logic                  mem_req_valid_out;
  logic                  mem_req_write_out;
  logic [ADDR_WIDTH-1:0] mem_req_addr_out;
  logic [DATA_WIDTH-1:0] mem_req_wdata_out;
  logic [MASK_WIDTH-1:0] mem_req_mask_out;
  logic                  mem_req_ready_in;
  logic                  mem_rsp_valid_in;
  logic [DATA_WIDTH-1:0] mem_rsp_data_in;

  logic                  busy_out;
  logic                  protocol_err_out;

  modport slave (
    input  fetch_req_in, fetch_addr_in,
    output fetch_ready_out, fetch_rsp_valid_out, fetch_rsp_data_out,
    input  data_read_in, data_write_in, data_addr_in, data_wdata_in, data_mask_in,
    output data_ready_out, data_rsp_valid_out, data_rsp_data_out,
    output mem_req_valid_out, mem_req_write_out, mem_req_addr_out,
    output mem_req_wdata_out, mem_req_mask_out,
    input  mem_req_ready_in, mem_rsp_valid_in, mem_rsp_data_in,
    output busy_out, protocol_err_out
  );

  modport master (
    output fetch_req_in, fetch_addr_in,
    input  fetch_ready_out, fetch_rsp_valid_out, fetch_rsp_data_out,
    output data_read_in, data_write_in, data_addr_in, data_wdata_in, data_mask_in,
    input  data_ready_out, data_rsp_valid_out, data_rsp_data_out,
    input  mem_req_valid_out, mem_req_write_out, mem_req_addr_out,
    input  mem_req_wdata_out, mem_req_mask_out,
    output mem_req_ready_in, mem_rsp_valid_in, mem_rsp_data_in,
    input  busy_out, protocol_err_out
  );
endinterface

// File: rtl/exec_mem_port_arbiter.sv
// rtl/exec_mem_port_arbiter.sv - shares one memory port between instruction fetch and execute load/store
//
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : exec_mem_port_arbiter_if.slave (fetch channel, data channel, memory channel, status)
// Data requests win arbitration; a streak counter forces a fetch grant after
// FETCH_STARVE_LIMIT consecutive data grants with fetch waiting. At most one
// request is outstanding; read responses are routed back to the issuing requester.
module exec_mem_port_arbiter #(
  parameter int ADDR_WIDTH         = 32,
  parameter int DATA_WIDTH         = 32,
  parameter int MASK_WIDTH         = 8,
  parameter int FETCH_STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  exec_mem_port_arbiter_if.slave        bus
);
  localparam int            SW         = $clog2(FETCH_STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(FETCH_STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_t;

  state_t                state_q, state_d;
  logic [SW-1:0]         streak_q, streak_d;
  logic                  owner_q, owner_d;            // 1 = data, 0 = fetch

  logic                  fetch_ready_q, fetch_ready_d;
  logic                  fetch_rsp_valid_q, fetch_rsp_valid_d;
  logic [DATA_WIDTH-1:0] fetch_rsp_data_q, fetch_rsp_data_d;
  logic                  data_ready_q, data_ready_d;
  logic                  data_rsp_valid_q, data_rsp_valid_d;
  logic [DATA_WIDTH-1:0] data_rsp_data_q, data_rsp_data_d;
  logic                  req_valid_q, req_valid_d;
  logic                  req_write_q, req_write_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;
  logic [MASK_WIDTH-1:0] req_mask_q, req_mask_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;

  logic                  data_pending;
  logic                  fetch_forced;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      streak_q          <= '0;
      owner_q           <= 1'b0;
      fetch_ready_q     <= 1'b0;
      fetch_rsp_valid_q <= 1'b0;
      fetch_rsp_data_q  <= '0;
      data_ready_q      <= 1'b0;
      data_rsp_valid_q  <= 1'b0;
      data_rsp_data_q   <= '0;
      req_valid_q       <= 1'b0;
      req_write_q       <= 1'b0;
      req_addr_q        <= '0;
      req_wdata_q       <= '0;
      req_mask_q        <= '0;
      busy_q            <= 1'b0;
      err_q             <= 1'b0;
    end else begin
      state_q           <= state_d;
      streak_q          <= streak_d;
      owner_q           <= owner_d;
      fetch_ready_q     <= fetch_ready_d;
      fetch_rsp_valid_q <= fetch_rsp_valid_d;
      fetch_rsp_data_q  <= fetch_rsp_data_d;
      data_ready_q      <= data_ready_d;
      data_rsp_valid_q  <= data_rsp_valid_d;
      data_rsp_data_q   <= data_rsp_data_d;
      req_valid_q       <= req_valid_d;
      req_write_q       <= req_write_d;
      req_addr_q        <= req_addr_d;
      req_wdata_q       <= req_wdata_d;
      req_mask_q        <= req_mask_d;
      busy_q            <= busy_d;
      err_q             <= err_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    streak_d          = streak_q;
    owner_d           = owner_q;
    fetch_ready_d     = 1'b0;
    fetch_rsp_valid_d = 1'b0;
    fetch_rsp_data_d  = fetch_rsp_data_q;
    data_ready_d      = 1'b0;
    data_rsp_valid_d  = 1'b0;
    data_rsp_data_d   = data_rsp_data_q;
    req_valid_d       = req_valid_q;
    req_write_d       = req_write_q;
    req_addr_d        = req_addr_q;
    req_wdata_d       = req_wdata_q;
    req_mask_d        = req_mask_q;
    err_d             = err_q;

    data_pending = bus.data_read_in | bus.data_write_in;
    fetch_forced = bus.fetch_req_in && (streak_q == STREAK_MAX);

    // The streak only counts data grants made while fetch is actually waiting.
    if (!bus.fetch_req_in) streak_d = '0;

    case (state_q)
      IDLE: begin
        if (data_pending && !fetch_forced) begin
          // A simultaneous read stays pending behind the store.
          data_ready_d = 1'b1;
          owner_d      = 1'b1;
          req_valid_d  = 1'b1;
          req_write_d  = bus.data_write_in;
          req_addr_d   = bus.data_addr_in;
          req_wdata_d  = bus.data_wdata_in;
          req_mask_d   = bus.data_mask_in;
          state_d      = REQ;
          if (bus.fetch_req_in && streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
        end else if (bus.fetch_req_in) begin
          fetch_ready_d = 1'b1;
          owner_d       = 1'b0;
          req_valid_d   = 1'b1;
          req_write_d   = 1'b0;
          req_addr_d    = bus.fetch_addr_in;
          req_wdata_d   = '0;
          req_mask_d    = '1;
          state_d       = REQ;
          streak_d      = '0;
        end
      end
      REQ: begin
        if (bus.mem_req_ready_in) begin
          req_valid_d = 1'b0;
          state_d     = req_write_q ? IDLE : WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (bus.mem_rsp_valid_in) begin
          state_d = IDLE;
          if (owner_q) begin
            data_rsp_valid_d = 1'b1;
            data_rsp_data_d  = bus.mem_rsp_data_in;
          end else begin
            fetch_rsp_valid_d = 1'b1;
            fetch_rsp_data_d  = bus.mem_rsp_data_in;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Responses with nothing outstanding (including stragglers after a reset) are dropped.
    if (bus.mem_rsp_valid_in && state_q != WAIT_RSP) err_d = 1'b1;

    busy_d = (state_d != IDLE);
  end

  assign bus.fetch_ready_out     = fetch_ready_q;
  assign bus.fetch_rsp_valid_out = fetch_rsp_valid_q;
  assign bus.fetch_rsp_data_out  = fetch_rsp_data_q;
  assign bus.data_ready_out      = data_ready_q;
  assign bus.data_rsp_valid_out  = data_rsp_valid_q;
  assign bus.data_rsp_data_out   = data_rsp_data_q;
  assign bus.mem_req_valid_out   = req_valid_q;
  assign bus.mem_req_write_out   = req_write_q;
  assign bus.mem_req_addr_out    = req_addr_q;
  assign bus.mem_req_wdata_out   = req_wdata_q;
  assign bus.mem_req_mask_out    = req_mask_q;
  assign bus.busy_out            = busy_q;
  assign bus.protocol_err_out    = err_q;
endmodule

// File: tb/tb_exec_mem_port_arbiter.sv
// tb/tb_exec_mem_port_arbiter.sv - directed self-checking bench for exec_mem_port_arbiter
module tb_exec_mem_port_arbiter;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  exec_mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MASK_WIDTH(8)) bus ();

  exec_mem_port_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MASK_WIDTH(8), .FETCH_STARVE_LIMIT(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for a grant pulse: who = 1 data, 0 fetch, -1 none within the budget.
  task automatic wait_grant(output int who);
    who = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.data_ready_out) begin who = 1; break; end
      if (bus.fetch_ready_out) begin who = 0; break; end
    end
  endtask

  // Complete the read just granted (memory ready already high), then respond.
  task automatic finish_read(input logic [31:0] d);
    step();
    bus.mem_rsp_valid_in = 1'b1;
    bus.mem_rsp_data_in  = d;
    step();
    bus.mem_rsp_valid_in = 1'b0;
  endtask

  initial begin
    int who;
    int exp_who [10];
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.fetch_req_in     = 1'b0;
    bus.fetch_addr_in    = '0;
    bus.data_read_in     = 1'b0;
    bus.data_write_in    = 1'b0;
    bus.data_addr_in     = '0;
    bus.data_wdata_in    = '0;
    bus.data_mask_in     = '0;
    bus.mem_req_ready_in = 1'b0;
    bus.mem_rsp_valid_in = 1'b0;
    bus.mem_rsp_data_in  = '0;
    step();
    step();
    reset = 1'b0;

    check("rst_fetch_ready", bus.fetch_ready_out, 0);
    check("rst_data_ready", bus.data_ready_out, 0);
    check("rst_req_valid", bus.mem_req_valid_out, 0);
    check("rst_busy", bus.busy_out, 0);
    check("rst_err", bus.protocol_err_out, 0);

    // Fetch read at 0x100, response three cycles after acceptance.
    bus.fetch_req_in     = 1'b1;
    bus.fetch_addr_in    = 32'h100;
    bus.mem_req_ready_in = 1'b1;
    step();
    check("f_ready", bus.fetch_ready_out, 1);
    check("f_data_ready", bus.data_ready_out, 0);
    check("f_valid", bus.mem_req_valid_out, 1);
    check("f_addr", bus.mem_req_addr_out, 32'h100);
    check("f_write", bus.mem_req_write_out, 0);
    check("f_mask", bus.mem_req_mask_out, 8'hFF);
    check("f_wdata", bus.mem_req_wdata_out, 0);
    bus.fetch_req_in = 1'b0;
    step();
    check("f_valid_drop", bus.mem_req_valid_out, 0);
    check("f_ready_pulse", bus.fetch_ready_out, 0);
    check("f_busy_wait", bus.busy_out, 1);
    step();
    step();
    bus.mem_rsp_valid_in = 1'b1;
    bus.mem_rsp_data_in  = 32'h13;
    step();
    bus.mem_rsp_valid_in = 1'b0;
    check("f_rsp_valid", bus.fetch_rsp_valid_out, 1);
    check("f_rsp_data", bus.fetch_rsp_data_out, 32'h13);
    check("f_rsp_other", bus.data_rsp_valid_out, 0);
    check("f_busy_done", bus.busy_out, 0);
    step();
    check("f_rsp_pulse", bus.fetch_rsp_valid_out, 0);
    check("f_rsp_hold", bus.fetch_rsp_data_out, 32'h13);

    // Simultaneous fetch 0x104 and load 0x2000: load first, fetch right after.
    bus.fetch_req_in  = 1'b1;
    bus.fetch_addr_in = 32'h104;
    bus.data_read_in  = 1'b1;
    bus.data_addr_in  = 32'h2000;
    step();
    check("s_data_ready", bus.data_ready_out, 1);
    check("s_fetch_ready", bus.fetch_ready_out, 0);
    check("s_addr", bus.mem_req_addr_out, 32'h2000);
    bus.data_read_in = 1'b0;
    finish_read(32'hCAFE0001);
    check("s_drsp_valid", bus.data_rsp_valid_out, 1);
    check("s_drsp_data", bus.data_rsp_data_out, 32'hCAFE0001);
    check("s_frsp_quiet", bus.fetch_rsp_valid_out, 0);
    step();
    check("s_fetch_grant", bus.fetch_ready_out, 1);
    check("s_fetch_addr", bus.mem_req_addr_out, 32'h104);
    bus.fetch_req_in = 1'b0;
    finish_read(32'h93);
    check("s_frsp_valid", bus.fetch_rsp_valid_out, 1);
    check("s_frsp_data", bus.fetch_rsp_data_out, 32'h93);
    check("s_drsp_quiet", bus.data_rsp_valid_out, 0);
    check("s_drsp_hold", bus.data_rsp_data_out, 32'hCAFE0001);
    step();

    // Store with memory stalling three cycles.
    bus.data_write_in    = 1'b1;
    bus.data_addr_in     = 32'h2000;
    bus.data_wdata_in    = 32'hDEADBEEF;
    bus.data_mask_in     = 8'h0F;
    bus.mem_req_ready_in = 1'b0;
    step();
    check("w_ready", bus.data_ready_out, 1);
    bus.data_write_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("w_valid", bus.mem_req_valid_out, 1);
      check("w_write", bus.mem_req_write_out, 1);
      check("w_addr", bus.mem_req_addr_out, 32'h2000);
      check("w_wdata", bus.mem_req_wdata_out, 32'hDEADBEEF);
      check("w_mask", bus.mem_req_mask_out, 8'h0F);
      check("w_busy", bus.busy_out, 1);
      check("w_no_rsp", {bus.fetch_rsp_valid_out, bus.data_rsp_valid_out}, 0);
      bus.mem_req_ready_in = (i == 3);
      step();
    end
    check("w_valid_drop", bus.mem_req_valid_out, 0);
    check("w_busy_drop", bus.busy_out, 0);
    check("w_no_rsp_end", {bus.fetch_rsp_valid_out, bus.data_rsp_valid_out}, 0);

    // Starvation guard: loads and fetch held continuously.
    bus.fetch_req_in  = 1'b1;
    bus.fetch_addr_in = 32'h300;
    bus.data_read_in  = 1'b1;
    bus.data_addr_in  = 32'h4000;
    exp_who = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    for (int g = 0; g < 10; g++) begin
      wait_grant(who);
      check($sformatf("starve_grant%0d", g), who, exp_who[g]);
      finish_read(32'h1000 + g);
    end
    bus.fetch_req_in = 1'b0;
    bus.data_read_in = 1'b0;
    step();

    // Read and write together: store goes first, read follows.
    bus.data_read_in  = 1'b1;
    bus.data_write_in = 1'b1;
    bus.data_addr_in  = 32'h5000;
    bus.data_wdata_in = 32'h11111111;
    bus.data_mask_in  = 8'h03;
    step();
    check("rw_ready1", bus.data_ready_out, 1);
    check("rw_write1", bus.mem_req_write_out, 1);
    bus.data_write_in = 1'b0;
    step();
    check("rw_idle_valid", bus.mem_req_valid_out, 0);
    check("rw_idle_busy", bus.busy_out, 0);
    step();
    check("rw_ready2", bus.data_ready_out, 1);
    check("rw_write2", bus.mem_req_write_out, 0);
    check("rw_valid2", bus.mem_req_valid_out, 1);
    bus.data_read_in = 1'b0;
    finish_read(32'h55);
    check("rw_rsp", bus.data_rsp_data_out, 32'h55);
    check("rw_no_err", bus.protocol_err_out, 0);
    step();

    // Reset in WAIT_RSP, then a stray response two cycles later.
    bus.fetch_req_in  = 1'b1;
    bus.fetch_addr_in = 32'h600;
    step();
    bus.fetch_req_in = 1'b0;
    step();
    check("r_in_wait", bus.busy_out, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("r_busy", bus.busy_out, 0);
    check("r_valid", bus.mem_req_valid_out, 0);
    check("r_addr", bus.mem_req_addr_out, 0);
    check("r_mask", bus.mem_req_mask_out, 0);
    check("r_frsp_data", bus.fetch_rsp_data_out, 0);
    check("r_drsp_data", bus.data_rsp_data_out, 0);
    check("r_err", bus.protocol_err_out, 0);
    step();
    bus.mem_rsp_valid_in = 1'b1;
    bus.mem_rsp_data_in  = 32'h77;
    step();
    bus.mem_rsp_valid_in = 1'b0;
    check("r_no_frsp", bus.fetch_rsp_valid_out, 0);
    check("r_no_drsp", bus.data_rsp_valid_out, 0);
    check("r_frsp_data_kept", bus.fetch_rsp_data_out, 0);
    check("r_err_set", bus.protocol_err_out, 1);
    step();
    step();
    check("r_err_sticky", bus.protocol_err_out, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("r_err_clear", bus.protocol_err_out, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/exec_mem_port_arbiter.md
Name: exec_mem_port_arbiter

Overview:
- Shares the CPU's single memory port between instruction fetch (reads) and the execute stage's load/store requests.
- Registers the granted request and drives a valid/ready request channel toward memory. Tracks the one outstanding read and routes its response back to the requester that issued it.
- Data requests have priority, because the execute instruction is older. A streak counter guarantees fetch forward progress.

Parameters:
ADDR_WIDTH, 32, address width on all channels
DATA_WIDTH, 32, read/write data width
MASK_WIDTH, 8, byte-mask width (same as execute mem_write_mask)
FETCH_STARVE_LIMIT, 4, maximum consecutive data grants while fetch is pending; must be >= 1

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
fetch_req_in  in  1  fetch read request (level; held until accepted)
fetch_addr_in  in  ADDR_WIDTH  fetch address
fetch_ready_out  out  1  one-cycle pulse: fetch request accepted
fetch_rsp_valid_out  out  1  one-cycle pulse: fetch read data valid
fetch_rsp_data_out  out  DATA_WIDTH  fetch read data
data_read_in  in  1  execute load request (level)
data_write_in  in  1  execute store request (level)
data_addr_in  in  ADDR_WIDTH  load/store address
data_wdata_in  in  DATA_WIDTH  store data
data_mask_in  in  MASK_WIDTH  byte mask
data_ready_out  out  1  one-cycle pulse: data request accepted
data_rsp_valid_out  out  1  one-cycle pulse: load data valid
data_rsp_data_out  out  DATA_WIDTH  load data
mem_req_valid_out  out  1  memory request valid
mem_req_write_out  out  1  1 = store, 0 = read
mem_req_addr_out  out  ADDR_WIDTH  request address
mem_req_wdata_out  out  DATA_WIDTH  store data
mem_req_mask_out  out  MASK_WIDTH  byte mask
mem_req_ready_in  in  1  memory accepts the request
mem_rsp_valid_in  in  1  read response valid
mem_rsp_data_in  in  DATA_WIDTH  read response data
busy_out  out  1  state != IDLE
protocol_err_out  out  1  sticky: response received outside WAIT_RSP

Behaviour:
- All outputs are registered. Reset value of every output is 0.
- On reset: state = IDLE, streak = 0, owner = FETCH, protocol_err_out cleared.
- States are IDLE, REQ and WAIT_RSP.
- IDLE, when at least one request is pending:
  - Arbitrate: data wins unless (fetch_req_in && streak == FETCH_STARVE_LIMIT).
  - Latch the winner's payload into the mem_req_* registers and pulse the winner's ready_out.
  - Next state is REQ, with mem_req_valid_out = 1 in the cycle after the grant.
- Fetch payload mapping: write = 0, mask = all ones, wdata = 0.
- Data payload mapping:
  - data_write_in has precedence over data_read_in if both are high; only the write is issued.
  - The read remains pending if still asserted.
- Streak counter:
  - Increments on a data grant while fetch_req_in = 1, saturating at FETCH_STARVE_LIMIT.
  - Clears on a fetch grant, or in any cycle with fetch_req_in = 0.
- REQ:
  - mem_req_* are held stable until mem_req_ready_in = 1.
  - On acceptance, mem_req_valid_out drops next cycle.
  - Store: next state is IDLE; no response is generated.
  - Read: record owner and go to WAIT_RSP.
- WAIT_RSP:
  - On mem_rsp_valid_in, the owner's rsp_valid_out pulses next cycle with the data, and state returns to IDLE.
  - The non-owner rsp_valid_out stays 0.
  - rsp_data outputs hold their last value when rsp_valid is low.
- No new grant is made while in REQ or WAIT_RSP; requests wait (at most one outstanding).
- Minimum occupancy:
  - Store: 2 cycles (grant, then REQ with ready).
  - Read: 3 cycles plus memory latency.
- A new grant may occur in the same cycle the FSM returns to IDLE from a response, i.e. the IDLE cycle itself.
- mem_rsp_valid_in in IDLE or REQ: ignored (no rsp pulse) and sets protocol_err_out. This includes late responses after a mid-operation reset.
- Reset mid-REQ: mem_req_valid_out drops the next cycle without completing. Requesters must re-request; ready_out was already consumed.
- Requester deasserting a request before its ready_out: legal; the request is simply not granted.

Test Plan:
- Fetch read: fetch_req_in = 1, addr 0x100; mem ready immediately; rsp 3 cycles later with 0x00000013. Required: fetch_ready_out pulses at cycle 0; mem_req_valid_out high for cycle 1 only; fetch_rsp_valid_out pulses with 0x13 one cycle after mem_rsp_valid_in.
- Simultaneous fetch (0x104) and load (0x2000). Required: data_ready_out first and load issued first; data_rsp_valid_out gets its data; fetch granted in the IDLE cycle after the data response; fetch_rsp routed correctly.
- Store: addr 0x2000, wdata 0xDEADBEEF, mask 0x0F; mem_req_ready_in low for 3 cycles. Required: mem_req_* stable for 4 cycles with write = 1; no rsp_valid on either side; busy_out drops the cycle after acceptance.
- Starvation, LIMIT = 4: continuous loads plus fetch held high. Required: exactly 4 data grants, then one fetch grant, then data resumes; streak = 0 after the fetch grant.
- data_read_in and data_write_in both high. Required: store issued (mem_req_write_out = 1); read issued on the next grant if still asserted.
- Reset asserted in WAIT_RSP, then mem_rsp_valid_in 2 cycles later. Required: all outputs 0 after reset; no rsp_valid pulse; protocol_err_out = 1 and sticky until the next reset.
